// File: rtl/mano_bus_sink.sv
// Register file and memory-write sink for a Mano-style common-bus CPU datapath.
// Latency: register updates take effect one edge after their enable; mem_req rises the cycle after mem_write.
// Backpressure: one write in flight; mem_write while busy is dropped and flagged by a one-cycle wr_drop pulse.
`timescale 1ns/1ps
module mano_bus_sink #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       bus_data,
  input  logic [5:0]        ld_vec,
  input  logic [5:0]        inc_vec,
  input  logic [5:0]        clr_vec,
  input  logic              sc_inc,
  input  logic              sc_clr,
  input  logic              mem_write,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] ar,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       dr,
  output logic [15:0]       ac,
  output logic [15:0]       ir,
  output logic [15:0]       tr,
  output logic [3:0]        sc,
  output logic [15:0]       t_dec,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              wr_busy,
  output logic              wr_drop
);

  // Bit positions inside ld_vec / inc_vec / clr_vec.
  localparam int IDX_AR = 0;
  localparam int IDX_PC = 1;
  localparam int IDX_DR = 2;
  localparam int IDX_AC = 3;
  localparam int IDX_IR = 4;
  localparam int IDX_TR = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Architectural registers.
  logic [ADDR_W-1:0] r_ar;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_dr;
  logic [15:0]       r_ac;
  logic [15:0]       r_ir;
  logic [15:0]       r_tr;
  logic [3:0]        r_sc;

  // Write-port state.
  state_t            r_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_wr_drop;

  // Next-state values.
  logic [ADDR_W-1:0] w_ar_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       w_dr_nxt;
  logic [15:0]       w_ac_nxt;
  logic [15:0]       w_ir_nxt;
  logic [15:0]       w_tr_nxt;
  logic [3:0]        w_sc_nxt;
  state_t            w_state_nxt;
  logic              w_busy;
  logic              w_wr_accept;
  logic              w_wr_reject;
  logic [15:0]       w_t_dec;

  // Address-width register update: load beats increment beats clear, else hold.
  // Load keeps only the low ADDR_W bits of the bus; increment wraps silently.
  function automatic logic [ADDR_W-1:0] f_upd_addr(
    input logic [ADDR_W-1:0] cur,
    input logic [15:0]       d,
    input logic              ld,
    input logic              inc,
    input logic              clr
  );
    logic [ADDR_W-1:0] v;
    v = cur;
    if (ld) begin
      v = d[ADDR_W-1:0];
    end else if (inc) begin
      v = cur + ADDR_W'(1);
    end else if (clr) begin
      v = '0;
    end
    return v;
  endfunction

  // 16-bit register update with the same priority; increment wraps 0xFFFF -> 0.
  function automatic logic [15:0] f_upd_word(
    input logic [15:0] cur,
    input logic [15:0] d,
    input logic        ld,
    input logic        inc,
    input logic        clr
  );
    logic [15:0] v;
    v = cur;
    if (ld) begin
      v = d;
    end else if (inc) begin
      v = cur + 16'd1;
    end else if (clr) begin
      v = '0;
    end
    return v;
  endfunction

  // Address registers: each has its own enable triple, so all may change together.
  always_comb begin
    w_ar_nxt = f_upd_addr(r_ar, bus_data, ld_vec[IDX_AR], inc_vec[IDX_AR], clr_vec[IDX_AR]);
    w_pc_nxt = f_upd_addr(r_pc, bus_data, ld_vec[IDX_PC], inc_vec[IDX_PC], clr_vec[IDX_PC]);
  end

  // Data registers: independent of each other and of AR/PC.
  always_comb begin
    w_dr_nxt = f_upd_word(r_dr, bus_data, ld_vec[IDX_DR], inc_vec[IDX_DR], clr_vec[IDX_DR]);
    w_ac_nxt = f_upd_word(r_ac, bus_data, ld_vec[IDX_AC], inc_vec[IDX_AC], clr_vec[IDX_AC]);
    w_ir_nxt = f_upd_word(r_ir, bus_data, ld_vec[IDX_IR], inc_vec[IDX_IR], clr_vec[IDX_IR]);
    w_tr_nxt = f_upd_word(r_tr, bus_data, ld_vec[IDX_TR], inc_vec[IDX_TR], clr_vec[IDX_TR]);
  end

  // Sequence counter: clear wins over increment; increment wraps 15 -> 0.
  always_comb begin
    w_sc_nxt = r_sc;
    if (sc_clr) begin
      w_sc_nxt = 4'd0;
    end else if (sc_inc) begin
      w_sc_nxt = r_sc + 4'd1;
    end
  end

  // Timing-signal decode: exactly one bit set, at position sc.
  always_comb begin
    w_t_dec        = '0;
    w_t_dec[r_sc]  = 1'b1;
  end

  // Register file and sequence counter; reset overrides every enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar <= '0;
      r_pc <= '0;
      r_dr <= '0;
      r_ac <= '0;
      r_ir <= '0;
      r_tr <= '0;
      r_sc <= '0;
    end else begin
      r_ar <= w_ar_nxt;
      r_pc <= w_pc_nxt;
      r_dr <= w_dr_nxt;
      r_ac <= w_ac_nxt;
      r_ir <= w_ir_nxt;
      r_tr <= w_tr_nxt;
      r_sc <= w_sc_nxt;
    end
  end

  // Write FSM state register; reset abandons any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write FSM next state: IDLE takes a request, REQ waits for ack; ack in IDLE is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_write) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Write FSM outputs: request is simply "in REQ"; accept/reject classify mem_write.
  always_comb begin
    w_busy      = (r_state == S_REQ);
    w_wr_accept = (r_state == S_IDLE) && mem_write;
    w_wr_reject = (r_state == S_REQ) && mem_write;
  end

  // Capture address/data only when a write is accepted, so they stay stable while REQ.
  // r_ar here is the pre-edge value, so a same-cycle AR load does not leak into the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_wr_accept) begin
      r_mem_addr  <= r_ar;
      r_mem_wdata <= bus_data;
    end
  end

  // Drop flag: one-cycle pulse after a mem_write that arrived while busy (ack cycle included).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_reject;
    end
  end

  assign ar        = r_ar;
  assign pc        = r_pc;
  assign dr        = r_dr;
  assign ac        = r_ac;
  assign ir        = r_ir;
  assign tr        = r_tr;
  assign sc        = r_sc;
  assign t_dec     = w_t_dec;
  assign wr_busy   = w_busy;
  assign mem_req   = w_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wr_drop   = r_wr_drop;

endmodule

// File: tb/tb_mano_bus_sink.sv
// Bench for mano_bus_sink: directed vectors push hand-computed post-edge snapshots and
// expected writes into queues; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_mano_bus_sink;

  logic        clk;
  logic        rst;
  logic [15:0] bus_data;
  logic [5:0]  ld_vec;
  logic [5:0]  inc_vec;
  logic [5:0]  clr_vec;
  logic        sc_inc;
  logic        sc_clr;
  logic        mem_write;
  logic        mem_ack;
  logic [11:0] ar;
  logic [11:0] pc;
  logic [15:0] dr;
  logic [15:0] ac;
  logic [15:0] ir;
  logic [15:0] tr;
  logic [3:0]  sc;
  logic [15:0] t_dec;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        wr_busy;
  logic        wr_drop;

  mano_bus_sink #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_data  (bus_data),
    .ld_vec    (ld_vec),
    .inc_vec   (inc_vec),
    .clr_vec   (clr_vec),
    .sc_inc    (sc_inc),
    .sc_clr    (sc_clr),
    .mem_write (mem_write),
    .mem_ack   (mem_ack),
    .ar        (ar),
    .pc        (pc),
    .dr        (dr),
    .ac        (ac),
    .ir        (ir),
    .tr        (tr),
    .sc        (sc),
    .t_dec     (t_dec),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_busy   (wr_busy),
    .wr_drop   (wr_drop)
  );

  typedef struct {
    logic [11:0] ar;
    logic [11:0] pc;
    logic [15:0] dr;
    logic [15:0] ac;
    logic [15:0] ir;
    logic [15:0] tr;
    logic [3:0]  sc;
    logic [15:0] t_dec;
    logic        req;
    logic        drop;
    logic [11:0] maddr;
    logic [15:0] mwdata;
  } snap_t;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  snap_t exp_q[$];
  wr_t   wr_q[$];

  int checks   = 0;
  int failures = 0;
  int step     = 0;

  // Expected post-edge state, set by hand before each cycle.
  logic [11:0] e_ar, e_pc, e_maddr;
  logic [15:0] e_dr, e_ac, e_ir, e_tr, e_mwdata;
  logic [3:0]  e_sc;
  logic        e_req, e_drop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst       = 1'b0;
    bus_data  = 16'h0000;
    ld_vec    = 6'b0;
    inc_vec   = 6'b0;
    clr_vec   = 6'b0;
    sc_inc    = 1'b0;
    sc_clr    = 1'b0;
    mem_write = 1'b0;
    mem_ack   = 1'b0;
  endtask

  // Apply the currently driven inputs for one edge, then queue the expected result.
  task automatic cyc();
    snap_t s;
    @(posedge clk);
    #1;
    s.ar     = e_ar;
    s.pc     = e_pc;
    s.dr     = e_dr;
    s.ac     = e_ac;
    s.ir     = e_ir;
    s.tr     = e_tr;
    s.sc     = e_sc;
    s.t_dec  = 16'h0001 << e_sc;
    s.req    = e_req;
    s.drop   = e_drop;
    s.maddr  = e_maddr;
    s.mwdata = e_mwdata;
    exp_q.push_back(s);
    clear_inputs();
  endtask

  task automatic expect_all_zero();
    e_ar = '0; e_pc = '0; e_dr = '0; e_ac = '0; e_ir = '0; e_tr = '0;
    e_sc = '0; e_req = 1'b0; e_drop = 1'b0; e_maddr = '0; e_mwdata = '0;
  endtask

  // Monitor: compare one snapshot per cycle, and check each new write request against wr_q.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    snap_t s;
    wr_t   w;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      step++;
      chk($sformatf("s%0d.ar", step), 32'(ar), 32'(s.ar));
      chk($sformatf("s%0d.pc", step), 32'(pc), 32'(s.pc));
      chk($sformatf("s%0d.dr", step), 32'(dr), 32'(s.dr));
      chk($sformatf("s%0d.ac", step), 32'(ac), 32'(s.ac));
      chk($sformatf("s%0d.ir", step), 32'(ir), 32'(s.ir));
      chk($sformatf("s%0d.tr", step), 32'(tr), 32'(s.tr));
      chk($sformatf("s%0d.sc", step), 32'(sc), 32'(s.sc));
      chk($sformatf("s%0d.t_dec", step), 32'(t_dec), 32'(s.t_dec));
      chk($sformatf("s%0d.mem_req", step), 32'(mem_req), 32'(s.req));
      chk($sformatf("s%0d.wr_busy", step), 32'(wr_busy), 32'(s.req));
      chk($sformatf("s%0d.wr_drop", step), 32'(wr_drop), 32'(s.drop));
      chk($sformatf("s%0d.mem_addr", step), 32'(mem_addr), 32'(s.maddr));
      chk($sformatf("s%0d.mem_wdata", step), 32'(mem_wdata), 32'(s.mwdata));
    end
    if (mem_req === 1'b1 && prev_req == 1'b0) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected: got request addr %h data %h, required none", mem_addr, mem_wdata);
      end else begin
        w = wr_q.pop_front();
        chk("wr.addr", 32'(mem_addr), 32'(w.addr));
        chk("wr.data", 32'(mem_wdata), 32'(w.data));
      end
    end
    prev_req = (mem_req === 1'b1);
  end

  initial begin
    wr_t w;
    clear_inputs();
    expect_all_zero();

    // Reset for two edges.
    rst = 1'b1; cyc();
    rst = 1'b1; cyc();

    // Load AR and PC together; upper bus nibble discarded.
    ld_vec = 6'b000011; bus_data = 16'hABCD; e_ar = 12'hBCD; e_pc = 12'hBCD; cyc();

    // AC: load beats inc and clr; inc wraps 0xFFFF.
    ld_vec = 6'b001000; bus_data = 16'hFFFF; e_ac = 16'hFFFF; cyc();
    ld_vec = 6'b001000; inc_vec = 6'b001000; clr_vec = 6'b001000; bus_data = 16'h1234;
    e_ac = 16'h1234; cyc();
    ld_vec = 6'b001000; bus_data = 16'hFFFF; e_ac = 16'hFFFF; cyc();
    inc_vec = 6'b001000; e_ac = 16'h0000; cyc();

    // PC wrap 0xFFF -> 0x000.
    ld_vec = 6'b000010; bus_data = 16'h0FFF; e_pc = 12'hFFF; cyc();
    inc_vec = 6'b000010; e_pc = 12'h000; cyc();

    // DR: inc beats clr, then clr alone.
    ld_vec = 6'b000100; bus_data = 16'h0005; e_dr = 16'h0005; cyc();
    inc_vec = 6'b000100; clr_vec = 6'b000100; e_dr = 16'h0006; cyc();
    clr_vec = 6'b000100; e_dr = 16'h0000; cyc();

    // Independent enables on three registers in one cycle.
    ld_vec = 6'b010000; inc_vec = 6'b100000; clr_vec = 6'b000001; bus_data = 16'h8001;
    e_ir = 16'h8001; e_tr = 16'h0001; e_ar = 12'h000; cyc();
    ld_vec = 6'b000001; bus_data = 16'hF123; e_ar = 12'h123; cyc();
    inc_vec = 6'b000001; ld_vec = 6'b000100; bus_data = 16'hC0DE; e_ar = 12'h124; e_dr = 16'hC0DE; cyc();
    ld_vec = 6'b000001; bus_data = 16'h0FFF; e_ar = 12'hFFF; cyc();
    inc_vec = 6'b000001; e_ar = 12'h000; cyc();

    // Sequence counter walks 1..15 then wraps to 0.
    for (int i = 1; i <= 16; i++) begin
      sc_inc = 1'b1; e_sc = 4'(i); cyc();
    end
    sc_inc = 1'b1; e_sc = 4'd1; cyc();
    sc_inc = 1'b1; e_sc = 4'd2; cyc();
    sc_inc = 1'b1; e_sc = 4'd3; cyc();
    sc_inc = 1'b1; sc_clr = 1'b1; e_sc = 4'd0; cyc();
    sc_inc = 1'b1; e_sc = 4'd1; cyc();
    sc_clr = 1'b1; e_sc = 4'd0; cyc();

    // Write with a same-cycle AR load: the write uses the old AR (0x010).
    ld_vec = 6'b000001; bus_data = 16'h0010; e_ar = 12'h010; cyc();
    mem_write = 1'b1; ld_vec = 6'b000001; bus_data = 16'h5A5A;
    e_ar = 12'hA5A; e_req = 1'b1; e_maddr = 12'h010; e_mwdata = 16'h5A5A;
    w.addr = 12'h010; w.data = 16'h5A5A; wr_q.push_back(w);
    cyc();
    // Write while busy is dropped; latched values untouched.
    mem_write = 1'b1; bus_data = 16'h1111; e_drop = 1'b1; cyc();
    e_drop = 1'b0; cyc();
    // Ack on the third cycle, with a competing write that must also be dropped.
    mem_ack = 1'b1; mem_write = 1'b1; bus_data = 16'h2222; e_req = 1'b0; e_drop = 1'b1; cyc();
    e_drop = 1'b0; cyc();
    // Stray ack while idle changes nothing.
    mem_ack = 1'b1; cyc();

    // New write from AR = 0xA5A, then reset while it is pending.
    mem_write = 1'b1; bus_data = 16'h7777; e_req = 1'b1; e_maddr = 12'hA5A; e_mwdata = 16'h7777;
    w.addr = 12'hA5A; w.data = 16'h7777; wr_q.push_back(w);
    cyc();
    rst = 1'b1; mem_ack = 1'b1; mem_write = 1'b1; ld_vec = 6'h3F; inc_vec = 6'h3F; sc_inc = 1'b1;
    bus_data = 16'hFFFF; expect_all_zero(); cyc();
    mem_ack = 1'b1; cyc();

    // First writes after reset behave normally.
    mem_write = 1'b1; ld_vec = 6'b000010; bus_data = 16'h0BEE;
    e_pc = 12'hBEE; e_req = 1'b1; e_maddr = 12'h000; e_mwdata = 16'h0BEE;
    w.addr = 12'h000; w.data = 16'h0BEE; wr_q.push_back(w);
    cyc();
    mem_ack = 1'b1; e_req = 1'b0; cyc();
    cyc();

    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
